usb_tx_wire_writer: RTL



---
 rtl/usb_tx_wire_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/usb_tx_wire_writer.sv
// usb_tx_wire_writer
//   Final transmit stage of the USB serial interface engine. Buffers 2-bit line
//   symbols from the TX wire arbiter in a small FIFO and replays each one onto
//   the transceiver pins for exactly one full-speed or low-speed bit period.
//
// Parameters:
//   FIFO_DEPTH  buffered symbols (power of two, >= 2)
//   FS_DIV      clk cycles per full-speed bit
//   LS_DIV      clk cycles per low-speed bit
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   TxBitsIn      {D+, D-} symbol from the arbiter
//   TxCtlIn       1 = drive the line, 0 = tristate for this bit time
//   TxFSRateIn    1 = full-speed bit period, 0 = low-speed
//   USBWireWEn    write strobe, accepted only while USBWireRdy = 1
//   USBWireRdy    FIFO can accept a symbol this cycle
//   TxBitsOut     registered {D+, D-} to the transceiver
//   TxCtlOut      registered output enable to the transceiver
//   TxBusy        FIFO non-empty or line currently driven
//   TxOverflow    sticky rejected-write flag (only with USB_TX_WIRE_OVERFLOW_FLAG_EN)
//
// Build option:
//   USB_TX_WIRE_OVERFLOW_FLAG_EN  adds the TxOverflow output.

module usb_tx_wire_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FS_DIV     = 4,
    parameter int unsigned LS_DIV     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TxBitsIn,
    input  logic       TxCtlIn,
    input  logic       TxFSRateIn,
    input  logic       USBWireWEn,
    output logic       USBWireRdy,
    output logic [1:0] TxBitsOut,
    output logic       TxCtlOut,
`ifdef USB_TX_WIRE_OVERFLOW_FLAG_EN
    output logic       TxOverflow,
`endif
    output logic       TxBusy
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned MaxDiv = (FS_DIV > LS_DIV) ? FS_DIV : LS_DIV;
    localparam int unsigned RateW  = $clog2(MaxDiv) + 1;

    localparam logic [CntW-1:0]  FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [RateW-1:0] FsLoad  = RateW'(FS_DIV - 1);
    localparam logic [RateW-1:0] LsLoad  = RateW'(LS_DIV - 1);

    // Entry layout: {ctl, fsRate, bits[1:0]}
    logic [3:0]       fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic [CntW-1:0]  count;
    logic [RateW-1:0] rateCnt;
    logic [3:0]       headEntry;
    logic             tick;
    logic             push;
    logic             pop;

    assign USBWireRdy = (count != FullCnt);
    assign TxBusy     = (count != '0) | TxCtlOut;
    assign headEntry  = fifoMem[rdPtr];
    assign tick       = (rateCnt == '0);
    assign push       = USBWireWEn & USBWireRdy;
    assign pop        = tick & (count != '0);

    // Storage needs no reset; the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= {TxCtlIn, TxFSRateIn, TxBitsIn};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            rateCnt   <= '0;
            TxBitsOut <= 2'b00;
            TxCtlOut  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                // Rate is taken from the popped entry, so it only changes at a bit boundary.
                rdPtr     <= rdPtr + 1'b1;
                TxBitsOut <= headEntry[1:0];
                TxCtlOut  <= headEntry[3];
                rateCnt   <= headEntry[2] ? FsLoad : LsLoad;
            end else if (tick) begin
                // Idle: release the line but leave the last bits on the pins.
                TxCtlOut <= 1'b0;
            end else begin
                rateCnt <= rateCnt - 1'b1;
            end
        end
    end

`ifdef USB_TX_WIRE_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            TxOverflow <= 1'b0;
        end else if (USBWireWEn & ~USBWireRdy) begin
            TxOverflow <= 1'b1;
        end
    end
`endif

endmodule
